// File: rtl/fft_twiddle_addr_gen.sv
// Twiddle ROM request sequencer for a radix-2 DIT FFT of length 2^L. Requests are
// credit-limited against a small output FIFO that tags each word with stage/last.
module fft_twiddle_addr_gen #(
  parameter int unsigned MAX_FFT_LENGTH_LOG2 = 12,
  parameter int unsigned MIN_FFT_LENGTH_LOG2 = 3,
  parameter int unsigned ROM_ADDR_WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH          = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [3:0]                fft_length_log2_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  output logic                      rom_addr_valid_o,
  input  logic [31:0]               rom_data_i,
  input  logic                      rom_data_valid_i,
  output logic [31:0]               tw_data_o,
  output logic [3:0]                tw_stage_o,
  output logic                      tw_last_o,
  output logic                      tw_valid_o,
  input  logic                      tw_ready_i
);

  localparam int unsigned LW   = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = MAX_FFT_LENGTH_LOG2 - 1;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = AW + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_e;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [LW-1:0] stage;
    logic          last;
  } tw_entry_t;

  state_e                    state_q, state_d;
  logic [LW-1:0]             l_q, l_d, s_q, s_d;
  logic [BW-1:0]             b_q, b_d;
  logic                      busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                      rom_addr_valid_q;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr_q;
  logic [LW-1:0]             req_stage_q, rsp_stage_q;
  logic                      req_last_q, rsp_last_q;
  logic                      inflight_q, inflight_d;

  tw_entry_t                 mem_q [FIFO_DEPTH];
  logic [AW-1:0]             wptr_q, rptr_q;
  logic [CNTW-1:0]           count_q, count_d;
  tw_entry_t                 head_c;

  logic                      start_ok_c, issue_c, last_issue_c, push_c, pop_c;
  logic [BW-1:0]             b_max_c, b_mask_c;
  logic [LW-1:0]             shift_c;
  logic [CW-1:0]             outstanding_c;
  logic [ROM_ADDR_WIDTH-1:0] addr_c;

  // Credits cover FIFO occupancy, the returning word and the request on the bus.
  assign head_c        = mem_q[rptr_q];
  assign tw_valid_o    = (count_q != '0);
  assign pop_c         = tw_valid_o && tw_ready_i;
  assign push_c        = rom_data_valid_i && inflight_q;
  assign outstanding_c = CW'(count_q) + CW'(inflight_q) + CW'(rom_addr_valid_q) - CW'(pop_c);
  assign issue_c       = (state_q == ISSUE) && (outstanding_c < CW'(FIFO_DEPTH));

  assign start_ok_c   = (fft_length_log2_i >= LW'(MIN_FFT_LENGTH_LOG2)) &&
                        (fft_length_log2_i <= LW'(MAX_FFT_LENGTH_LOG2));
  assign b_max_c      = BW'((32'd1 << (l_q - LW'(1))) - 32'd1);
  assign last_issue_c = (s_q == (l_q - LW'(1))) && (b_q == b_max_c);

  // The two shifts by (L-1-s) and (MAX-L) collapse into one shift by MAX-1-s.
  assign b_mask_c = (BW'(1) << s_q) - BW'(1);
  assign shift_c  = LW'(MAX_FFT_LENGTH_LOG2 - 1) - s_q;
  assign addr_c   = ROM_ADDR_WIDTH'(b_q & b_mask_c) << shift_c;

  always_ff @(posedge clk_i) begin : state_reg
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && start_ok_c) state_d = ISSUE;
      ISSUE:   if (issue_c && last_issue_c) state_d = DRAIN;
      DRAIN:   if (pop_c && head_c.last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    l_d    = l_q;
    s_d    = s_q;
    b_d    = b_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    busy_d = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start_i && start_ok_c) begin
          l_d = fft_length_log2_i;
          s_d = '0;
          b_d = '0;
        end else if (start_i) begin
          err_d = 1'b1;
        end
      end
      ISSUE: begin
        if (issue_c) begin
          if (b_q == b_max_c) begin
            b_d = '0;
            s_d = s_q + LW'(1);
          end else begin
            b_d = b_q + BW'(1);
          end
        end
      end
      DRAIN:   done_d = pop_c && head_c.last;
      default: ;
    endcase
  end

  always_comb begin : inflight_next
    inflight_d = inflight_q;
    if (rom_addr_valid_q && !push_c)      inflight_d = 1'b1;
    else if (!rom_addr_valid_q && push_c) inflight_d = 1'b0;
  end

  assign count_d = count_q + CNTW'(push_c) - CNTW'(pop_c);

  always_ff @(posedge clk_i) begin : ctrl_regs
    if (reset_i) begin
      l_q              <= '0;
      s_q              <= '0;
      b_q              <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      rom_addr_valid_q <= 1'b0;
      rom_addr_q       <= '0;
      req_stage_q      <= '0;
      req_last_q       <= 1'b0;
      rsp_stage_q      <= '0;
      rsp_last_q       <= 1'b0;
      inflight_q       <= 1'b0;
    end else begin
      l_q              <= l_d;
      s_q              <= s_d;
      b_q              <= b_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      err_q            <= err_d;
      rom_addr_valid_q <= issue_c;
      if (issue_c) begin
        rom_addr_q  <= addr_c;
        req_stage_q <= s_q;
        req_last_q  <= last_issue_c;
      end
      rsp_stage_q      <= req_stage_q;
      rsp_last_q       <= req_last_q;
      inflight_q       <= inflight_d;
    end
  end

  always_ff @(posedge clk_i) begin : fifo_ptrs
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_c) wptr_q <= wptr_q + AW'(1);
      if (pop_c)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin : fifo_mem
    if (push_c) mem_q[wptr_q] <= '{data: rom_data_i, stage: rsp_stage_q, last: rsp_last_q};
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign rom_addr_o       = rom_addr_q;
  assign rom_addr_valid_o = rom_addr_valid_q;
  assign tw_data_o        = tw_valid_o ? head_c.data  : '0;
  assign tw_stage_o       = tw_valid_o ? head_c.stage : '0;
  assign tw_last_o        = tw_valid_o && head_c.last;

endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
// Directed bench for fft_twiddle_addr_gen with a 1-cycle-latency ROM model and
// table-driven expected twiddle sequences.
module tb_fft_twiddle_addr_gen;

  localparam int MAXL = 12;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  fft_length_log2_i = 4'd0;
  logic        busy_o, done_o, err_o;
  logic [15:0] rom_addr_o;
  logic        rom_addr_valid_o;
  logic [31:0] rom_data_i = 32'h0;
  logic        rom_data_valid_i = 1'b0;
  logic [31:0] tw_data_o;
  logic [3:0]  tw_stage_o;
  logic        tw_last_o, tw_valid_o;
  logic        tw_ready_i = 1'b0;

  fft_twiddle_addr_gen dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .start_i           (start_i),
    .fft_length_log2_i (fft_length_log2_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .err_o             (err_o),
    .rom_addr_o        (rom_addr_o),
    .rom_addr_valid_o  (rom_addr_valid_o),
    .rom_data_i        (rom_data_i),
    .rom_data_valid_i  (rom_data_valid_i),
    .tw_data_o         (tw_data_o),
    .tw_stage_o        (tw_stage_o),
    .tw_last_o         (tw_last_o),
    .tw_valid_o        (tw_valid_o),
    .tw_ready_i        (tw_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return {a ^ 16'hA5A5, a};
  endfunction

  // ROM model: request seen in cycle c answers during cycle c+1.
  logic        req_v = 1'b0;
  logic [15:0] req_a = 16'h0;
  always @(negedge clk_i) begin
    req_v = rom_addr_valid_o;
    req_a = rom_addr_o;
  end
  always @(posedge clk_i) begin
    #1;
    rom_data_valid_i = req_v;
    rom_data_i       = req_v ? rom_word(req_a) : 32'h0;
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [31:0] got_d [$];
  logic [3:0]  got_s [$];
  logic        got_l [$];
  logic [15:0] req_q [$];
  int first_hs = 0, last_hs = 0, done_cyc = 0, done_cnt = 0, err_cnt = 0;

  always @(negedge clk_i) begin
    if (tw_valid_o && tw_ready_i) begin
      if (got_d.size() == 0) first_hs = cyc;
      got_d.push_back(tw_data_o);
      got_s.push_back(tw_stage_o);
      got_l.push_back(tw_last_o);
      last_hs = cyc;
    end
    if (rom_addr_valid_o) req_q.push_back(rom_addr_o);
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_o) err_cnt++;
  end

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  stage;
    logic        last;
  } vec_t;
  vec_t l3_tab [12];

  typedef struct {
    logic [3:0]  l;
    int          total;
    logic [15:0] last_addr;
    int          last_stage;
  } xf_t;
  xf_t xf_tab [3];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_mon();
    got_d.delete();
    got_s.delete();
    got_l.delete();
    req_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic start_pulse(input logic [3:0] l);
    start_i = 1'b1;
    fft_length_log2_i = l;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      tick();
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, ok, 1);
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string name);
    logic [57:0] v;
    v = {busy_o, done_o, err_o, rom_addr_valid_o, rom_addr_o, tw_data_o,
         tw_stage_o, tw_last_o, tw_valid_o};
    check(name, longint'(v), 0);
  endtask

  function automatic logic [15:0] exp_addr(input int l, input int idx);
    int half, s, b, e;
    half = 1 << (l - 1);
    s = idx / half;
    b = idx % half;
    e = (b % (1 << s)) << (l - 1 - s);
    return 16'(e << (MAXL - l));
  endfunction

  task automatic check_stream(input string name, input int l);
    int n, mism;
    logic [15:0] a;
    n = l * (1 << (l - 1));
    mism = 0;
    if (got_d.size() != n || req_q.size() != n) mism++;
    else begin
      for (int i = 0; i < n; i++) begin
        a = exp_addr(l, i);
        if (req_q[i] !== a || got_d[i] !== rom_word(a) ||
            got_s[i] !== 4'(i / (1 << (l - 1))) || got_l[i] !== (i == n - 1))
          mism++;
      end
    end
    check({name, "_stream_mismatches"}, mism, 0);
  endtask

  task automatic check_l3(input string tag);
    check({tag, "_count"}, got_d.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < got_d.size() && i < req_q.size()) begin
        check({tag, "_addr"},  req_q[i], l3_tab[i].addr);
        check({tag, "_data"},  got_d[i], rom_word(l3_tab[i].addr));
        check({tag, "_stage"}, got_s[i], l3_tab[i].stage);
        check({tag, "_last"},  got_l[i], l3_tab[i].last);
      end
    end
  endtask

  initial begin
    logic [15:0] l3_addr [12];
    logic [31:0] hold;
    int hi, nreq;

    l3_addr = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1024, 16'd0, 16'd1024,
                16'd0, 16'd512, 16'd1024, 16'd1536};
    for (int i = 0; i < 12; i++) begin
      l3_tab[i].addr  = l3_addr[i];
      l3_tab[i].stage = 4'(i / 4);
      l3_tab[i].last  = (i == 11);
    end
    xf_tab[0] = '{l: 4'd4,  total: 32,    last_addr: 16'd1792, last_stage: 3};
    xf_tab[1] = '{l: 4'd5,  total: 80,    last_addr: 16'd1920, last_stage: 4};
    xf_tab[2] = '{l: 4'd12, total: 24576, last_addr: 16'd2047, last_stage: 11};

    // Reset state
    reset_i = 1'b1;
    tick(); tick(); tick();
    check_all_zero("reset_outputs");
    reset_i = 1'b0;
    tick();

    // L=3 with consumer always ready
    tw_ready_i = 1'b1;
    clear_mon();
    start_pulse(4'd3);
    check("l3_busy_hi", busy_o, 1);
    wait_done("l3");
    check_l3("l3");
    check("l3_done_latency", done_cyc - last_hs, 1);
    check("l3_done_count", done_cnt, 1);
    check("l3_busy_after", busy_o, 0);

    // Longer transforms, continuous output
    for (int t = 0; t < 3; t++) begin
      clear_mon();
      start_pulse(xf_tab[t].l);
      check("xf_busy_hi", busy_o, 1);
      wait_done("xf");
      check("xf_count", got_d.size(), xf_tab[t].total);
      if (got_d.size() > 0 && req_q.size() > 0) begin
        check("xf_final_addr", req_q[req_q.size() - 1], xf_tab[t].last_addr);
        check("xf_final_stage", got_s[got_s.size() - 1], xf_tab[t].last_stage);
        check("xf_final_last", got_l[got_l.size() - 1], 1);
      end
      check("xf_no_gaps", last_hs - first_hs + 1, xf_tab[t].total);
      check("xf_done_latency", done_cyc - last_hs, 1);
      check_stream("xf", int'(xf_tab[t].l));
    end

    // Out-of-range lengths
    clear_mon();
    start_pulse(4'd2);
    check("err_l2_pulse", err_o, 1);
    check("err_l2_busy", busy_o, 0);
    tick();
    check("err_l2_clears", err_o, 0);
    start_pulse(4'd13);
    check("err_l13_pulse", err_o, 1);
    check("err_l13_busy", busy_o, 0);
    tick(); tick(); tick();
    check("err_no_requests", req_q.size(), 0);
    check("err_pulse_count", err_cnt, 2);

    // Start while busy is ignored
    clear_mon();
    start_pulse(4'd3);
    tick(); tick(); tick();
    start_pulse(4'd4);
    wait_done("mid");
    check_l3("mid");
    check("mid_no_err", err_cnt, 0);
    check("mid_done_count", done_cnt, 1);

    // Backpressure: consumer stalled for 20 cycles after first output
    tw_ready_i = 1'b0;
    clear_mon();
    start_pulse(4'd5);
    hi = 0;
    for (int i = 0; i < 50 && !tw_valid_o; i++) tick();
    check("bp_first_output", tw_valid_o, 1);
    hold = tw_data_o;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 10 && rom_addr_valid_o) hi++;
    end
    check("bp_reqs_at_most_depth", (req_q.size() <= 4) && (req_q.size() > 0), 1);
    check("bp_valid_low_no_credit", hi, 0);
    check("bp_head_stable", tw_data_o, hold);
    check("bp_valid_held", tw_valid_o, 1);
    tw_ready_i = 1'b1;
    wait_done("bp");
    check_stream("bp", 5);

    // Reset with a request on the bus; its late response must be dropped
    clear_mon();
    start_pulse(4'd3);
    nreq = 0;
    for (int i = 0; i < 50 && nreq < 3; i++) begin
      @(negedge clk_i);
      if (rom_addr_valid_o) nreq++;
    end
    check("rst_req_seen", nreq, 3);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_all_zero("rst_mid_outputs");
    reset_i = 1'b0;
    clear_mon();
    tick();
    check("rst_late_word_dropped", tw_valid_o, 0);
    tick(); tick(); tick();
    check("rst_nothing_out", got_d.size(), 0);
    check("rst_no_requests", req_q.size(), 0);
    start_pulse(4'd3);
    wait_done("rst");
    check_l3("rst");
    check("rst_done_latency", done_cyc - last_hs, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_twiddle_addr_gen.md
Name: fft_twiddle_addr_gen

Overview:
- Sequences twiddle-factor fetches for a radix-2 DIT FFT of runtime-selectable length N = 2^L.
- Sits directly upstream of the twiddle ROM: drives its address/valid port and captures its returned {cos,sin} word.
- Buffers the returned words in a small FIFO and streams them, tagged with stage and end markers, to the butterfly datapath over a valid/ready handshake.
- Credit-limits ROM requests so that backpressure from the butterfly never drops a ROM word.

Parameters:
- MAX_FFT_LENGTH_LOG2, 12: largest supported L; ROM grid is 2^MAX_FFT_LENGTH_LOG2 points.
- MIN_FFT_LENGTH_LOG2, 3: smallest supported L.
- ROM_ADDR_WIDTH, 16: width of the ROM address port.
- FIFO_DEPTH, 4: output FIFO entries, power of two ≥2; also the credit limit.

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  start pulse; sampled only in IDLE
- fft_length_log2_i  in  4  L; sampled with start_i
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle pulse after the final twiddle handshake
- err_o  out  1  one-cycle pulse when start_i is rejected
- rom_addr_o  out  ROM_ADDR_WIDTH  twiddle exponent on the 2^MAX grid, zero-extended
- rom_addr_valid_o  out  1  request strobe; one ROM read per high cycle
- rom_data_i  in  32  {cos[31:16], sin[15:0]} from ROM
- rom_data_valid_i  in  1  ROM response strobe; exactly 1 cycle after each request, no backpressure
- tw_data_o  out  32  twiddle word at the FIFO head
- tw_stage_o  out  4  stage index s of tw_data_o
- tw_last_o  out  1  marks the final twiddle of the transform
- tw_valid_o  out  1  FIFO non-empty
- tw_ready_i  in  1  consumer ready; transfer occurs when tw_valid_o && tw_ready_i

Behaviour:
- Reset: all outputs 0, FSM to IDLE, FIFO emptied, in-flight counter 0, counters cleared. A reset mid-operation aborts the transform immediately; a late rom_data_valid_i in the cycle after reset is discarded.
- FSM states IDLE, ISSUE, DRAIN.
- IDLE:
  - start_i with MIN ≤ L ≤ MAX: latch L, clear s and b, go to ISSUE.
  - start_i with L out of range: err_o pulse next cycle, remain in IDLE.
- ISSUE:
  - Assert rom_addr_valid_o in any cycle where fifo_count + inflight < FIFO_DEPTH.
  - Address = ((b mod 2^s) << (L-1-s)) << (MAX-L), where b = 0..N/2-1 and s = 0..L-1.
  - b increments per issue; it wraps to 0 at N/2-1, incrementing s.
  - After the issue with s=L-1, b=N/2-1, go to DRAIN.
- DRAIN: when FIFO is empty and inflight = 0 (last word consumed), pulse done_o, drop busy_o, go to IDLE.
- start_i while busy is ignored (no err_o).
- inflight is 0/1 (ROM latency 1). It increments on issue and decrements on rom_data_valid_i; simultaneous issue and return leaves it unchanged.
- FIFO entry = {rom_data_i, s_tag, last_tag}. Tags are piped alongside the request for one cycle. The FIFO never overflows by construction; an overflow is a design error.
- FIFO supports simultaneous push and pop when full or empty. Push on empty shows on tw_valid_o the next cycle (no fall-through).
- Total twiddles per transform = L·2^(L-1). tw_last_o is high only on the last one.
- Request-to-output latency with tw_ready_i held high = 2 cycles. Steady-state throughput = 1 twiddle/cycle when FIFO_DEPTH ≥ 2.
- tw_data_o, tw_stage_o, and tw_last_o are stable while tw_valid_o && !tw_ready_i.

Test Plan:
- L=3, tw_ready_i=1 → 12 twiddles.
  - Addresses: stage0 0,0,0,0; stage1 0,1024,0,1024; stage2 0,512,1024,1536.
  - tw_stage_o 0..2; tw_last_o on the 12th.
  - done_o exactly 1 cycle after the 12th handshake.
- L=12 → 24576 twiddles; the final address is 2047 with tw_stage_o=11; no gaps after the first output (tw_valid_o continuous).
- L=5, tw_ready_i low for 20 cycles after the first output:
  - At most 4 requests are issued in total until ready returns.
  - rom_addr_valid_o stays low while credits are exhausted.
  - All 80 words arrive in order, with no loss or duplicate.
- start_i with L=2 and with L=13 → err_o pulses, busy_o stays 0, no ROM requests.
- start_i pulsed again mid-transform with L=4 → ignored; the running L=3 sequence completes unchanged.
- reset_i asserted in ISSUE with 1 request in flight → next cycle all outputs 0. The returning rom_data_valid_i is dropped. A fresh L=3 start then produces the exact 12-word sequence.
